// File: rtl/fifo_stream_reader.sv
// Pulls words out of a show-ahead FIFO into a pending register and a 2-deep queue,
// presenting them as a valid/ready stream with tlast and per-packet beat counts.
module fifo_stream_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    output logic             o_fifo_r_stb,
    input  logic [WIDTH-1:0] i_fifo_r_data,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_last_r,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_pkt_len,
    output logic             o_pkt_done
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] p_data;
    logic             valid_p;
    logic [WIDTH-1:0] q_data [2];
    logic [1:0]       q_last;
    logic [1:0]       q_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_inc;
    logic [2:0]       occ_after;
    logic             pop;
    logic             wr_hi;

    always_comb begin
        o_tvalid  = (q_cnt != 2'd0);
        pop       = o_tvalid && i_tready;
        // occupancy of P plus Q once this cycle's pop has left
        occ_after = {1'b0, q_cnt} + {2'b00, valid_p} - {2'b00, pop};
        o_fifo_r_stb = !rst && i_enable && !i_fifo_empty && (occ_after < 3'd2);
        wr_hi     = (q_cnt == 2'd2) || ((q_cnt == 2'd1) && !pop);
        o_tdata   = q_data[0];
        o_tlast   = q_last[0];
        o_busy    = valid_p || o_tvalid;
        beat_inc  = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_data  <= '0;
            valid_p <= 1'b0;
        end else begin
            if (o_fifo_r_stb) begin
                p_data <= i_fifo_r_data;
            end
            valid_p <= o_fifo_r_stb;
        end
    end

    // Head lives in slot 0; a pop shifts slot 1 down, and a same-edge push lands
    // in whichever slot is the tail after that shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data[0] <= '0;
            q_data[1] <= '0;
            q_last    <= '0;
            q_cnt     <= '0;
        end else begin
            if (pop) begin
                q_data[0] <= q_data[1];
                q_last[0] <= q_last[1];
            end
            if (valid_p) begin
                if (wr_hi) begin
                    q_data[1] <= p_data;
                    q_last[1] <= i_fifo_last_r;
                end else begin
                    q_data[0] <= p_data;
                    q_last[0] <= i_fifo_last_r;
                end
            end
            q_cnt <= q_cnt + {1'b0, valid_p} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            o_pkt_len  <= '0;
            o_pkt_done <= 1'b0;
        end else begin
            o_pkt_done <= 1'b0;
            if (pop) begin
                if (o_tlast) begin
                    o_pkt_len  <= beat_inc;
                    beat_cnt   <= '0;
                    o_pkt_done <= 1'b1;
                end else begin
                    beat_cnt <= beat_inc;
                end
            end
        end
    end
endmodule
